alu_regfile_pipe: RTL and testbench

//   Parametrised two-stage execute unit: multi-port register file feeding an 8-op ALU, with result writeback.

---
 rtl/alu_regfile_pipe.sv | 134 +++++++++++++
 tb/tb_alu_regfile_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_pipe.sv
// Two-stage execute unit: bypassed register-file read into an 8-op ALU, with result writeback.
// Latency: 2 edges from issue to result_valid. Throughput is one op per cycle.
// Backpressure: none. The unit never stalls, and a missing issue_valid inserts a bubble.
module alu_regfile_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [2:0]        opcode,
    input  logic              c_in,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wb_en,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    output logic [DATA_W:0]   result,
    output logic              result_valid,
    output logic              carry_flag,
    output logic              zero_flag
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [2:0]        s1_op_q, s1_op_d;
    logic              s1_cin_q, s1_cin_d;
    logic [ADDR_W-1:0] s1_rd_q, s1_rd_d;
    logic              s1_wb_q, s1_wb_d;

    logic [DATA_W:0]   result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    logic [DATA_W:0]   alu_res;
    logic              wb_fire;
    logic [DATA_W-1:0] op_a, op_b;

    // ALU on the stage-1 operands. All ops are DATA_W+1 bits wide, and the carry/borrow lands in the MSB.
    always_comb begin
        alu_res = '0;
        case (s1_op_q)
            3'd0: alu_res = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{DATA_W{1'b0}}, s1_cin_q};
            3'd1: alu_res = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{DATA_W{1'b0}}, s1_cin_q};
            3'd2: alu_res = {1'b0, s1_b_q} + {1'b0, ~s1_a_q} + {{DATA_W{1'b0}}, ~s1_cin_q};
            3'd3: alu_res = {1'b0, s1_a_q | s1_b_q};
            3'd4: alu_res = {1'b0, s1_a_q & s1_b_q};
            3'd5: alu_res = {1'b0, ~s1_a_q & s1_b_q};
            3'd6: alu_res = {1'b0, s1_a_q ^ s1_b_q};
            default: alu_res = {1'b0, s1_a_q ~^ s1_b_q};
        endcase
    end

    assign wb_fire = s1_vld_q & s1_wb_q;

    // Operand select. A completing writeback beats a same-cycle external write, which beats the array.
    always_comb begin
        op_a = regs_q[rs1_addr];
        op_b = regs_q[rs2_addr];
        if (ext_we && ext_addr == rs1_addr) op_a = ext_data;
        if (ext_we && ext_addr == rs2_addr) op_b = ext_data;
        if (wb_fire && s1_rd_q == rs1_addr) op_a = alu_res[DATA_W-1:0];
        if (wb_fire && s1_rd_q == rs2_addr) op_b = alu_res[DATA_W-1:0];
    end

    // Next-state logic. The ALU writeback is applied after the external write so it wins on an address clash.
    always_comb begin
        regs_d = regs_q;
        if (ext_we) regs_d[ext_addr] = ext_data;
        if (wb_fire) regs_d[s1_rd_q] = alu_res[DATA_W-1:0];

        s1_vld_d = issue_valid;
        s1_a_d   = op_a;
        s1_b_d   = op_b;
        s1_op_d  = opcode;
        s1_cin_d = c_in;
        s1_rd_d  = rd_addr;
        s1_wb_d  = wb_en;

        result_valid_d = s1_vld_q;
        result_d       = result_q;
        carry_d        = carry_q;
        zero_d         = zero_q;
        if (s1_vld_q) begin
            result_d = alu_res;
            carry_d  = alu_res[DATA_W];
            zero_d   = (alu_res[DATA_W-1:0] == '0);
        end
    end

    // State registers. Reset clears the array and drops any in-flight op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            s1_vld_q       <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_op_q        <= '0;
            s1_cin_q       <= 1'b0;
            s1_rd_q        <= '0;
            s1_wb_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            s1_vld_q       <= s1_vld_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_op_q        <= s1_op_d;
            s1_cin_q       <= s1_cin_d;
            s1_rd_q        <= s1_rd_d;
            s1_wb_q        <= s1_wb_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            carry_q        <= carry_d;
            zero_q         <= zero_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign carry_flag   = carry_q;
    assign zero_flag    = zero_q;
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Self-checking bench for alu_regfile_pipe, with directed cases plus randomized traffic checked against a reference model.
// The result for an issue at edge k is checked at the falling edge after edge k+1.
// Inputs are driven just after the falling edge, and outputs are sampled on the falling edge.
module tb_alu_regfile_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, c_in, wb_en, ext_we;
    logic [2:0] opcode, rs1_addr, rs2_addr, rd_addr, ext_addr;
    logic [7:0] ext_data;
    logic [8:0] result;
    logic       result_valid, carry_flag, zero_flag;

    logic        w_issue_valid, w_c_in, w_wb_en, w_ext_we;
    logic [2:0]  w_opcode, w_rs1, w_rs2, w_rd, w_ext_addr;
    logic [15:0] w_ext_data;
    logic [16:0] w_result;
    logic        w_result_valid, w_carry, w_zero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_regfile_pipe #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .opcode(opcode), .c_in(c_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .wb_en(wb_en),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
        .result(result), .result_valid(result_valid), .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    alu_regfile_pipe #(.DATA_W(16), .ADDR_W(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .issue_valid(w_issue_valid), .opcode(w_opcode), .c_in(w_c_in),
        .rs1_addr(w_rs1), .rs2_addr(w_rs2), .rd_addr(w_rd), .wb_en(w_wb_en),
        .ext_we(w_ext_we), .ext_addr(w_ext_addr), .ext_data(w_ext_data),
        .result(w_result), .result_valid(w_result_valid), .carry_flag(w_carry), .zero_flag(w_zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers plus the one op in flight.
    logic [7:0] mregs [8];
    bit         pend_vld = 1'b0;
    logic [8:0] pend_res;
    bit         pend_wb;
    logic [2:0] pend_rd;
    logic [8:0] exp_res = '0;
    bit         exp_vld = 1'b0, exp_c = 1'b0, exp_z = 1'b0;

    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        int r;
        case (op)
            3'd0: r = a + b + cin;
            3'd1: r = a + (255 - b) + cin;
            3'd2: r = b + (255 - a) + (1 - cin);
            3'd3: r = a | b;
            3'd4: r = a & b;
            3'd5: r = (255 - a) & b;
            3'd6: r = a ^ b;
            default: r = 255 - (a ^ b);
        endcase
        return r[8:0];
    endfunction

    function automatic logic [7:0] ref_read(input logic [2:0] ad);
        if (pend_vld && pend_wb && pend_rd == ad) return pend_res[7:0];
        if (ext_we && ext_addr == ad) return ext_data;
        return mregs[ad];
    endfunction

    always @(posedge clk) begin
        logic [7:0] a, b;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
            pend_vld = 1'b0;
            exp_res = '0; exp_vld = 1'b0; exp_c = 1'b0; exp_z = 1'b0;
        end else begin
            a = ref_read(rs1_addr);
            b = ref_read(rs2_addr);
            exp_vld = pend_vld;
            if (pend_vld) begin
                exp_res = pend_res;
                exp_c   = pend_res[8];
                exp_z   = (pend_res[7:0] == 8'h00);
            end
            if (ext_we) mregs[ext_addr] = ext_data;
            if (pend_vld && pend_wb) mregs[pend_rd] = pend_res[7:0];
            pend_vld = issue_valid;
            pend_res = ref_alu(opcode, a, b, c_in);
            pend_wb  = wb_en;
            pend_rd  = rd_addr;
        end
    end

    // Every-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_result", 32'(result), 32'(exp_res));
            chk("m_valid", 32'(result_valid), 32'(exp_vld));
            chk("m_carry", 32'(carry_flag), 32'(exp_c));
            chk("m_zero", 32'(zero_flag), 32'(exp_z));
        end
    end

    task automatic cyc(input logic iv, input logic [2:0] op, input logic cin,
                       input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] rd,
                       input logic wb, input logic ew, input logic [2:0] ea, input logic [7:0] ed);
        issue_valid = iv; opcode = op; c_in = cin; rs1_addr = r1; rs2_addr = r2;
        rd_addr = rd; wb_en = wb; ext_we = ew; ext_addr = ea; ext_data = ed;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    // Issues OR of a register with itself, so the result is {0, reg}.
    task automatic read_reg(input logic [2:0] r, input logic [8:0] exp, input string nm);
        cyc(1'b1, 3'd3, 1'b0, r, r, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00);
        idle();
        chk(nm, 32'(result), 32'(exp));
    endtask

    initial begin
        w_issue_valid = 0; w_c_in = 0; w_wb_en = 0; w_ext_we = 0;
        w_opcode = 0; w_rs1 = 0; w_rs2 = 0; w_rd = 0; w_ext_addr = 0; w_ext_data = 0;
        rst_n = 1'b0;
        cyc(1'b1, 3'd0, 1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 8'h77);
        chk_en = 1'b1;
        cyc(1'b1, 3'd0, 1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 8'h77);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_valid", 32'(result_valid), 32'h0);
        chk("rst_carry", 32'(carry_flag), 32'h0);
        chk("rst_zero", 32'(zero_flag), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) read_reg(3'(i), 9'h000, "rst_reg");

        cyc(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd1, 8'h55);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd2, 8'hAA);

        cyc(1'b1, 3'd0, 1'b1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00);
        idle();
        chk("add_res", 32'(result), 32'h100);
        chk("add_valid", 32'(result_valid), 32'h1);
        chk("add_carry", 32'(carry_flag), 32'h1);
        chk("add_zero", 32'(zero_flag), 32'h1);

        cyc(1'b1, 3'd1, 1'b1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00);
        idle();
        chk("sub_res", 32'(result), 32'h0AB);
        chk("sub_carry", 32'(carry_flag), 32'h0);

        cyc(1'b1, 3'd2, 1'b0, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00);
        idle();
        chk("suba_res", 32'(result), 32'h155);
        chk("suba_carry", 32'(carry_flag), 32'h1);
        idle();
        chk("bubble_valid", 32'(result_valid), 32'h0);
        chk("bubble_hold", 32'(result), 32'h155);

        // r3 = r1 + r2, then immediately AND r3 with r1 through the bypass.
        cyc(1'b1, 3'd0, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 3'd0, 8'h00);
        cyc(1'b1, 3'd4, 1'b0, 3'd3, 3'd1, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00);
        chk("b2b_first", 32'(result), 32'h0FF);
        idle();
        chk("b2b_bypass", 32'(result), 32'h055);

        // An external write to the same register in the writeback cycle loses.
        cyc(1'b1, 3'd3, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd3, 8'h0F);
        read_reg(3'd3, 9'h0FF, "clash_r3");
        // An external write to a different register in the writeback cycle also commits.
        cyc(1'b1, 3'd4, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd4, 8'h0F);
        read_reg(3'd3, 9'h000, "split_r3");
        read_reg(3'd4, 9'h00F, "split_r4");

        // A reset on the completion edge discards the in-flight writeback.
        cyc(1'b1, 3'd6, 1'b0, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0, 3'd0, 8'h00);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("flight_valid", 32'(result_valid), 32'h0);
        chk("flight_result", 32'(result), 32'h0);
        read_reg(3'd5, 9'h000, "flight_r5");

        // Randomized traffic, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            cyc(($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                3'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
        end
        rst_n = 1'b1;
        idle();
        idle();

        // 16-bit instance, XNOR of 0x00FF and 0x0F0F.
        w_ext_we = 1; w_ext_addr = 3'd1; w_ext_data = 16'h00FF;
        idle();
        w_ext_addr = 3'd2; w_ext_data = 16'h0F0F;
        idle();
        w_ext_we = 0; w_issue_valid = 1; w_opcode = 3'd7; w_rs1 = 3'd1; w_rs2 = 3'd2;
        idle();
        w_issue_valid = 0;
        idle();
        chk("w16_exnor", 32'(w_result), 32'h0F00F);
        chk("w16_valid", 32'(w_result_valid), 32'h1);
        chk("w16_carry", 32'(w_carry), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
